mult_div_ctrl: RTL and testbench

- Sequencer for the iterative multiply/divide datapath that feeds the Hi/Lo registers in the multicycle MIPS core.
- Accepts a one-cycle start pulse from the main control FSM.
- Drives init/step/sign-fix strobes to the datapath, then commits the result through HiLoSrc/HiLoWrite.
- Reports busy/done so the main FSM can hold in its MULT/DIV wait state; flags divide-by-zero.

---
 rtl/mult_div_ctrl_pkg.sv | 23 ++
 rtl/mult_div_ctrl_if.sv | 29 ++
 rtl/mult_div_ctrl.sv | 89 ++++++++
 tb/tb_mult_div_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: FSM states, operation
// select values and Hi/Lo source select values used by the main controller.
package mult_div_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_FIX   = 3'd3,
    S_WRITE = 3'd4,
    S_EXC   = 3'd5
  } state_t;

  localparam logic MD_MULT       = 1'b0;
  localparam logic MD_DIV        = 1'b1;
  localparam logic HILO_SRC_MULT = 1'b0;
  localparam logic HILO_SRC_DIV  = 1'b1;

  function automatic logic hilo_src_for(input logic op);
    return (op == MD_DIV) ? HILO_SRC_DIV : HILO_SRC_MULT;
  endfunction

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Request/strobe bundle between the main control FSM (master) and the
// multiply/divide sequencer (slave).
interface mult_div_ctrl_if;
  logic start;
  logic op;
  logic abort;
  logic divisor_zero;
  logic md_sel;
  logic md_init;
  logic md_step;
  logic md_fix_sign;
  logic HiLoSrc;
  logic HiLoWrite;
  logic busy;
  logic done;
  logic div_zero_exc;

  modport master (
    output start, op, abort, divisor_zero,
    input  md_sel, md_init, md_step, md_fix_sign, HiLoSrc, HiLoWrite,
           busy, done, div_zero_exc
  );

  modport slave (
    input  start, op, abort, divisor_zero,
    output md_sel, md_init, md_step, md_fix_sign, HiLoSrc, HiLoWrite,
           busy, done, div_zero_exc
  );
endinterface

// File: rtl/mult_div_ctrl.sv
// Sequencer for the iterative MULT/DIV datapath: init, WIDTH step cycles,
// optional DIV sign fix, then a single Hi/Lo commit. Outputs are a Moore decode.
module mult_div_ctrl
  import mult_div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             op_q, op_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= MD_MULT;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      op_q  <= op_d;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_d    = op_q;
    unique case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          op_d    = bus.op;
          state_d = (bus.op == MD_DIV && bus.divisor_zero) ? S_EXC : S_INIT;
        end
      end
      S_INIT: begin
        cnt_d   = CNT_LOAD;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt - 1'b1;
        if (cnt == CNT_LAST) state_d = (op_q == MD_DIV) ? S_FIX : S_WRITE;
      end
      S_FIX:   state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      S_EXC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Exception flush from main control overrides every transition.
    if (bus.abort) state_d = S_IDLE;
  end

  always_comb begin
    bus.md_init      = 1'b0;
    bus.md_step      = 1'b0;
    bus.md_fix_sign  = 1'b0;
    bus.HiLoSrc      = HILO_SRC_MULT;
    bus.HiLoWrite    = 1'b0;
    bus.done         = 1'b0;
    bus.div_zero_exc = 1'b0;
    bus.busy         = (state != S_IDLE);
    bus.md_sel       = (state != S_IDLE) ? op_q : MD_MULT;
    unique case (state)
      S_INIT:  bus.md_init     = 1'b1;
      S_RUN:   bus.md_step     = 1'b1;
      S_FIX:   bus.md_fix_sign = 1'b1;
      S_WRITE: begin
        bus.HiLoWrite = 1'b1;
        bus.done      = 1'b1;
        bus.HiLoSrc   = hilo_src_for(op_q);
      end
      S_EXC:   bus.div_zero_exc = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: per-scenario tasks with a scoreboard
// of expected completion events (Hi/Lo commit or divide-by-zero exception).
module tb_mult_div_ctrl;
  import mult_div_ctrl_pkg::*;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mult_div_ctrl_if bus ();

  mult_div_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100us;
    $display("FAIL watchdog: time limit reached, got no summary want summary");
    $fatal(1, "watchdog expired");
  end

  typedef enum int {EV_WRITE, EV_EXC} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    logic     src;
    logic     we;
    logic     done;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t mon_ev;

  int   n_init = 0, n_step = 0, n_step_sel = 0, n_fix = 0;
  int   init_cyc = -1, first_step = -1, last_step = -1, fix_cyc = -1;
  logic prev_step = 1'b0;

  // Monitor: samples on the falling edge, away from DUT state updates.
  always @(negedge clk) begin
    if (bus.md_init === 1'b1) begin n_init++; init_cyc = cyc; end
    if (bus.md_step === 1'b1) begin
      n_step++;
      if (bus.md_sel === 1'b1) n_step_sel++;
      if (prev_step !== 1'b1) first_step = cyc;
      last_step = cyc;
    end
    prev_step = bus.md_step;
    if (bus.md_fix_sign === 1'b1) begin n_fix++; fix_cyc = cyc; end
    if (bus.HiLoWrite === 1'b1 || bus.done === 1'b1) begin
      mon_ev.kind = EV_WRITE; mon_ev.cyc = cyc; mon_ev.src = bus.HiLoSrc;
      mon_ev.we = bus.HiLoWrite; mon_ev.done = bus.done;
      obs_q.push_back(mon_ev);
    end
    if (bus.div_zero_exc === 1'b1) begin
      mon_ev.kind = EV_EXC; mon_ev.cyc = cyc; mon_ev.src = bus.HiLoSrc;
      mon_ev.we = bus.HiLoWrite; mon_ev.done = bus.done;
      obs_q.push_back(mon_ev);
    end
  end

  function automatic logic [8:0] outs();
    return {bus.md_sel, bus.md_init, bus.md_step, bus.md_fix_sign, bus.HiLoSrc,
            bus.HiLoWrite, bus.busy, bus.done, bus.div_zero_exc};
  endfunction

  task automatic push_exp(input ev_kind_t k, input int c, input logic src,
                          input logic we, input logic dn);
    ev_t e;
    e.kind = k; e.cyc = c; e.src = src; e.we = we; e.done = dn;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a falling edge; start is high for the cycle numbered t.
  task automatic pulse_start(input logic o, input logic dz, output int t);
    bus.start = 1'b1; bus.op = o; bus.divisor_zero = dz;
    t = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = 1'($urandom_range(0, 1));
    bus.divisor_zero = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input string name);
    ev_t e, o;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s: got no event, want kind=%0d at cyc %0d", name, e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.cyc !== e.cyc || o.src !== e.src ||
            o.we !== e.we || o.done !== e.done) begin
          errors++;
          $display("FAIL %s: got kind=%0d cyc=%0d src=%b we=%b done=%b, want kind=%0d cyc=%0d src=%b we=%b done=%b",
                   name, o.kind, o.cyc, o.src, o.we, o.done, e.kind, e.cyc, e.src, e.we, e.done);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL %s_extra: got %0d unexpected events (first kind=%0d cyc=%0d), want 0",
               name, obs_q.size(), obs_q[0].kind, obs_q[0].cyc);
    end
    obs_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0; bus.op = 1'b0; bus.abort = 1'b0; bus.divisor_zero = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== 9'b0) begin
      errors++; $display("FAIL reset_outs: got %b want %b", outs(), 9'b0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== 9'b0) begin
      errors++; $display("FAIL idle_outs: got %b want %b", outs(), 9'b0);
    end
    drain("reset_events");
  endtask

  task automatic test_mult();
    int t, s_init, s_step, s_sel, s_fix;
    s_init = n_init; s_step = n_step; s_sel = n_step_sel; s_fix = n_fix;
    pulse_start(MD_MULT, 1'b1, t);
    push_exp(EV_WRITE, t + 34, HILO_SRC_MULT, 1'b1, 1'b1);
    checks++;
    if (bus.md_init !== 1'b1 || bus.busy !== 1'b1 || bus.md_sel !== 1'b0) begin
      errors++; $display("FAIL mult_init: got init=%b busy=%b sel=%b want 1 1 0",
                         bus.md_init, bus.busy, bus.md_sel);
    end
    wait_until(t + 35);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL mult_busy_end: got %b want 0", bus.busy);
    end
    checks++;
    if (n_init - s_init !== 1 || init_cyc !== t + 1) begin
      errors++; $display("FAIL mult_init_cyc: got n=%0d cyc=%0d want 1 cyc=%0d",
                         n_init - s_init, init_cyc, t + 1);
    end
    checks++;
    if (n_step - s_step !== WIDTH || first_step !== t + 2 || last_step !== t + 33) begin
      errors++; $display("FAIL mult_steps: got n=%0d first=%0d last=%0d want %0d %0d %0d",
                         n_step - s_step, first_step, last_step, WIDTH, t + 2, t + 33);
    end
    checks++;
    if (n_fix - s_fix !== 0 || n_step_sel - s_sel !== 0) begin
      errors++; $display("FAIL mult_fix_sel: got fix=%0d sel_steps=%0d want 0 0",
                         n_fix - s_fix, n_step_sel - s_sel);
    end
    drain("mult_write");
  endtask

  task automatic test_div();
    int t, s_step, s_sel, s_fix;
    s_step = n_step; s_sel = n_step_sel; s_fix = n_fix;
    pulse_start(MD_DIV, 1'b0, t);
    push_exp(EV_WRITE, t + 35, HILO_SRC_DIV, 1'b1, 1'b1);
    wait_until(t + 36);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL div_busy_end: got %b want 0", bus.busy);
    end
    checks++;
    if (n_step - s_step !== WIDTH || n_step_sel - s_sel !== WIDTH || last_step !== t + 33) begin
      errors++; $display("FAIL div_steps: got n=%0d sel=%0d last=%0d want %0d %0d %0d",
                         n_step - s_step, n_step_sel - s_sel, last_step, WIDTH, WIDTH, t + 33);
    end
    checks++;
    if (n_fix - s_fix !== 1 || fix_cyc !== t + 34) begin
      errors++; $display("FAIL div_fix: got n=%0d cyc=%0d want 1 cyc=%0d",
                         n_fix - s_fix, fix_cyc, t + 34);
    end
    drain("div_write");
  endtask

  task automatic test_div_zero();
    int t, s_init, s_step;
    s_init = n_init; s_step = n_step;
    pulse_start(MD_DIV, 1'b1, t);
    push_exp(EV_EXC, t + 1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.busy !== 1'b1 || bus.md_sel !== 1'b1) begin
      errors++; $display("FAIL dz_busy: got busy=%b sel=%b want 1 1", bus.busy, bus.md_sel);
    end
    wait_until(t + 4);
    checks++;
    if (outs() !== 9'b0 || n_init - s_init !== 0 || n_step - s_step !== 0) begin
      errors++; $display("FAIL dz_idle: got outs=%b init=%0d step=%0d want 0 0 0",
                         outs(), n_init - s_init, n_step - s_step);
    end
    drain("dz_exc");
  endtask

  task automatic test_abort();
    int t, t2, s_step;
    s_step = n_step;
    pulse_start(MD_MULT, 1'b0, t);
    wait_until(t + 10);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (outs() !== 9'b0) begin
      errors++; $display("FAIL abort_idle: got %b want %b", outs(), 9'b0);
    end
    checks++;
    if (n_step - s_step !== 9) begin
      errors++; $display("FAIL abort_steps: got %0d want 9", n_step - s_step);
    end
    wait_until(t + 12);
    s_step = n_step;
    pulse_start(MD_MULT, 1'b0, t2);
    push_exp(EV_WRITE, t2 + 34, HILO_SRC_MULT, 1'b1, 1'b1);
    wait_until(t2 + 35);
    checks++;
    if (n_step - s_step !== WIDTH || bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort_restart: got steps=%0d busy=%b want %0d 0",
                         n_step - s_step, bus.busy, WIDTH);
    end
    drain("abort_restart");
  endtask

  task automatic test_back_to_back();
    int t, tw, t3, s_step, s_sel, s_init;
    s_step = n_step; s_sel = n_step_sel;
    pulse_start(MD_MULT, 1'b0, t);
    push_exp(EV_WRITE, t + 34, HILO_SRC_MULT, 1'b1, 1'b1);
    wait_until(t + 5);
    pulse_start(MD_DIV, 1'b1, tw);
    wait_until(t + 20);
    pulse_start(MD_DIV, 1'b0, tw);
    wait_until(t + 34);
    pulse_start(MD_DIV, 1'b0, tw);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_write_start: got busy=%b want 0", bus.busy);
    end
    pulse_start(MD_MULT, 1'b0, t3);
    push_exp(EV_WRITE, t3 + 34, HILO_SRC_MULT, 1'b1, 1'b1);
    wait_until(t3 + 35);
    checks++;
    if (n_step - s_step !== 2 * WIDTH || n_step_sel - s_sel !== 0) begin
      errors++; $display("FAIL b2b_steps: got n=%0d sel=%0d want %0d 0",
                         n_step - s_step, n_step_sel - s_sel, 2 * WIDTH);
    end
    drain("b2b_writes");
    s_init = n_init;
    bus.start = 1'b1; bus.abort = 1'b1; bus.op = MD_MULT;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs() !== 9'b0 || n_init - s_init !== 0) begin
      errors++; $display("FAIL abort_start_idle: got outs=%b init=%0d want 0 0",
                         outs(), n_init - s_init);
    end
    drain("abort_start_events");
  endtask

  task automatic test_reset_mid();
    int t, t2, s_step;
    pulse_start(MD_DIV, 1'b0, t);
    wait_until(t + 15);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (outs() !== 9'b0) begin
      errors++; $display("FAIL reset_mid_outs: got %b want %b", outs(), 9'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 9'b0) begin
      errors++; $display("FAIL reset_release_idle: got %b want %b", outs(), 9'b0);
    end
    drain("reset_mid_events");
    s_step = n_step;
    pulse_start(MD_MULT, 1'b0, t2);
    push_exp(EV_WRITE, t2 + 34, HILO_SRC_MULT, 1'b1, 1'b1);
    wait_until(t2 + 35);
    checks++;
    if (n_step - s_step !== WIDTH || first_step !== t2 + 2) begin
      errors++; $display("FAIL reset_fresh_steps: got n=%0d first=%0d want %0d %0d",
                         n_step - s_step, first_step, WIDTH, t2 + 2);
    end
    drain("reset_fresh_write");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
